// File: rtl/wind_nmea_pkg.sv
// Shared definitions for the wind NMEA scheduler.
//   - state_t      : scheduler FSM states
//   - ASCII_*      : framing / status characters used in the MWV sentence
//   - SENTENCE_LEN_* : sentence length with and without the "*hh" checksum
//   - hex_ascii()  : 4-bit nibble to uppercase ASCII hex digit
package wind_nmea_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DATA,
        CONVERT,
        SEND
    } state_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_V      = 8'h56;

    localparam int SENTENCE_LEN_CKS   = 22;
    localparam int SENTENCE_LEN_NOCKS = 19;
    localparam int IDX_W              = 5;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        // '0'..'9' -> 0x30..0x39, 'A'..'F' -> 0x41..0x46 (0x37 + 10 = 'A')
        return (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/wind_nmea_scheduler_if.sv
// Byte stream from the scheduler to the NMEA UART transmitter.
//   tx_data  : ASCII byte
//   tx_valid : tx_data valid (held with tx_data until accepted)
//   tx_ready : transmitter accepts the byte this cycle
// master = scheduler side, slave = UART TX side.
interface wind_nmea_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (repeated subtraction).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, loads bin
//   bin        : unsigned value 0..255
//   done       : 1-cycle pulse once the digits are final
//   hundreds, tens, ones : BCD digits, held until the next start
// Takes at most 2 hundreds steps + 9 tens steps, then one cycle to flag done.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic       busy_q;
    logic       done_q;
    logic [7:0] rem_q;
    logic [3:0] hund_q;
    logic [3:0] tens_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= 8'd0;
            hund_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                rem_q  <= bin;
                hund_q <= 4'd0;
                tens_q <= 4'd0;
            end else if (busy_q) begin
                if (rem_q >= 8'd100) begin
                    rem_q  <= rem_q - 8'd100;
                    hund_q <= hund_q + 4'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_q  <= rem_q - 8'd10;
                    tens_q <= tens_q + 4'd1;
                end else begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done     = done_q;
    assign hundreds = hund_q;
    assign tens     = tens_q;
    // After conversion the remainder is below 10, so its low nibble is the ones digit.
    assign ones     = rem_q[3:0];
endmodule

// File: rtl/wind_nmea_scheduler.sv
// Periodic anemometer sequencer and MWV sentence streamer.
// Every PERIOD_CYCLES clocks (while enable=1) a measurement is requested,
// the result (or a timeout) is converted to decimal and streamed as
// "$WIMWV,,R,ddd,N,s[*hh]" CR LF over the tx interface.
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable                : run periodic measurement/transmit
//   anemo_data/anemo_valid: measurement result (valid is a 1-cycle pulse)
//   meas_start            : 1-cycle measurement request
//   tx (master)           : tx_data / tx_valid / tx_ready byte stream
//   busy                  : FSM not IDLE
//   overrun, timeout_err  : sticky status, cleared by clr_status
// Build option: define MWV_CHECKSUM_EN to append "*hh" (22-byte sentence);
// without it the sentence is 19 bytes and no checksum logic exists.
module wind_nmea_scheduler
    import wind_nmea_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [7:0]                    anemo_data,
    input  logic                          anemo_valid,
    output logic                          meas_start,
    wind_nmea_scheduler_if.master         tx,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err,
    input  logic                          clr_status
);
    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
`ifdef MWV_CHECKSUM_EN
    localparam int SENT_LEN = SENTENCE_LEN_CKS;
`else
    localparam int SENT_LEN = SENTENCE_LEN_NOCKS;
`endif
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SENT_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       status_q, status_d;
`ifdef MWV_CHECKSUM_EN
    logic [7:0]       cks_q, cks_d;
`endif
    logic             tick;
    logic             bcd_start, bcd_done;
    logic [7:0]       bcd_bin;
    logic [3:0]       dig_h, dig_t, dig_o;
    logic [7:0]       byte_cur;

    bin2bcd_seq u_bcd (
        .clk      (clk),
        .rst_n    (reset_n),
        .start    (bcd_start),
        .bin      (bcd_bin),
        .done     (bcd_done),
        .hundreds (dig_h),
        .tens     (dig_t),
        .ones     (dig_o)
    );

    // Tick is the cycle in which the counter sits at its last value and wraps.
    assign tick  = enable && (cnt_q == CNT_LAST);
    assign cnt_d = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);

    // Sentence template; digits/status/checksum come from stable registers
    // so tx_data cannot change while a byte is stalled.
    always_comb begin
        byte_cur = 8'h00;
        case (idx_q)
            5'd0:  byte_cur = ASCII_DOLLAR;
            5'd1:  byte_cur = 8'h57;   // W
            5'd2:  byte_cur = 8'h49;   // I
            5'd3:  byte_cur = 8'h4D;   // M
            5'd4:  byte_cur = 8'h57;   // W
            5'd5:  byte_cur = 8'h56;   // V
            5'd6:  byte_cur = ASCII_COMMA;
            5'd7:  byte_cur = ASCII_COMMA;
            5'd8:  byte_cur = 8'h52;   // R
            5'd9:  byte_cur = ASCII_COMMA;
            5'd10: byte_cur = {4'h3, dig_h};
            5'd11: byte_cur = {4'h3, dig_t};
            5'd12: byte_cur = {4'h3, dig_o};
            5'd13: byte_cur = ASCII_COMMA;
            5'd14: byte_cur = 8'h4E;   // N
            5'd15: byte_cur = ASCII_COMMA;
            5'd16: byte_cur = status_q;
`ifdef MWV_CHECKSUM_EN
            5'd17: byte_cur = ASCII_STAR;
            5'd18: byte_cur = hex_ascii(cks_q[7:4]);
            5'd19: byte_cur = hex_ascii(cks_q[3:0]);
            5'd20: byte_cur = ASCII_CR;
            5'd21: byte_cur = ASCII_LF;
`else
            5'd17: byte_cur = ASCII_CR;
            5'd18: byte_cur = ASCII_LF;
`endif
            default: byte_cur = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        to_d          = to_q;
        idx_d         = idx_q;
        status_d      = status_q;
        bcd_start     = 1'b0;
        bcd_bin       = 8'd0;
`ifdef MWV_CHECKSUM_EN
        cks_d         = cks_q;
`endif
        // Clear first so a coincident set event below wins.
        if (clr_status) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end
        if (tick) begin
            pending_d = 1'b1;
            if (pending_q) overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable && pending_q) begin
                    pending_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                to_d    = '0;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                // Data arriving on the timeout cycle is still accepted.
                if (anemo_valid) begin
                    bcd_start = 1'b1;
                    bcd_bin   = anemo_data;
                    status_d  = ASCII_A;
                    state_d   = CONVERT;
                end else if (to_q == TO_LAST) begin
                    bcd_start     = 1'b1;
                    status_d      = ASCII_V;
                    timeout_err_d = 1'b1;
                    state_d       = CONVERT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            CONVERT: begin
                if (bcd_done) begin
                    idx_d   = '0;
`ifdef MWV_CHECKSUM_EN
                    cks_d   = 8'h00;
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
`ifdef MWV_CHECKSUM_EN
                    // XOR covers bytes strictly between '$' (0) and '*' (17).
                    if ((idx_q != 5'd0) && (idx_q < 5'd17)) cks_d = cks_q ^ byte_cur;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabled: drop any queued tick; a sentence in flight still completes.
        if (!enable) pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            to_q          <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            status_q      <= 8'h00;
`ifdef MWV_CHECKSUM_EN
            cks_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            status_q      <= status_d;
`ifdef MWV_CHECKSUM_EN
            cks_q         <= cks_d;
`endif
        end
    end

    assign meas_start  = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign tx.tx_valid = (state_q == SEND);
    assign tx.tx_data  = (state_q == SEND) ? byte_cur : 8'h00;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
endmodule
